// File: rtl/spi_slave_word.sv
// SPI slave with word-wide receive/transmit buffers, configurable CPOL/CPHA/bit order.
// SPI pins are synchronised into the clk domain; sclk edges are detected on the synchronised copy.
module spi_slave_word #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_next;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rx_sr, rx_next;
    logic [WIDTH-1:0] tx_sr, tx_adv;
    logic [WIDTH-1:0] tx_buf;

    logic lead, trail, sample_edge, shift_edge;
    logic start, stop, do_sample, do_shift, last_bit, reload;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_s3 <= CPOL;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign lead        = (sclk_s3 == CPOL) && (sclk_s2 != CPOL);
    assign trail       = (sclk_s3 != CPOL) && (sclk_s2 == CPOL);
    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // A shift edge seen with the counter at 0 is either the edge that presents
    // bit 0 (CPHA=1) or the trailing edge right after a reload (CPHA=0); neither advances.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s2) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_s2) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge && (cnt != '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign last_bit = do_sample && (cnt == CW'(WIDTH - 1));
    assign reload   = start || last_bit;

    always_comb begin
        if (MSB_FIRST) begin
            rx_next = {rx_sr[WIDTH-2:0], mosi_s2};
            tx_adv  = {tx_sr[WIDTH-2:0], 1'b0};
        end else begin
            rx_next = {mosi_s2, rx_sr[WIDTH-1:1]};
            tx_adv  = {1'b0, tx_sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            tx_buf    <= '0;
            tx_ready  <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (start) cnt <= '0;
            if (stop) begin
                frame_err <= (cnt != '0);
                cnt       <= '0;
            end

            if (do_sample) begin
                rx_sr <= rx_next;
                if (last_bit) begin
                    cnt      <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            if (reload)        tx_sr <= tx_buf;
            else if (do_shift) tx_sr <= tx_adv;

            // A load accepted in the same clk as a reload wins over re-arming tx_ready.
            if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (reload) begin
                tx_ready <= 1'b1;
            end
        end
    end

    assign miso = (state == ACTIVE) ? (MSB_FIRST ? tx_sr[WIDTH-1] : tx_sr[0]) : 1'b0;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: instance 0 is mode 0 MSB-first, instance 1 is CPOL=1/CPHA=1 LSB-first.
`timescale 1ns/1ps
module tb_spi_slave_word;

    localparam int W = 8;
    localparam int H = 8;   // clk cycles per sclk half period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   sclk_v, cs_v, mosi_v, txl;
    logic [1:0]   miso_w, txr, rxv, ferr;
    logic [W-1:0] txd [2];
    logic [W-1:0] rxd [2];

    spi_slave_word #(.WIDTH(W), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .sclk(sclk_v[0]), .cs_n(cs_v[0]), .mosi(mosi_v[0]),
        .miso(miso_w[0]), .tx_data(txd[0]), .tx_load(txl[0]), .tx_ready(txr[0]),
        .rx_data(rxd[0]), .rx_valid(rxv[0]), .frame_err(ferr[0])
    );

    spi_slave_word #(.WIDTH(W), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .sclk(sclk_v[1]), .cs_n(cs_v[1]), .mosi(mosi_v[1]),
        .miso(miso_w[1]), .tx_data(txd[1]), .tx_load(txl[1]), .tx_ready(txr[1]),
        .rx_data(rxd[1]), .rx_valid(rxv[1]), .frame_err(ferr[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid cycle pushes the word, every frame_err cycle is counted.
    logic [W-1:0] got_rx_q[$];
    int ferr_cnt = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rxv[i] === 1'b1) got_rx_q.push_back(rxd[i]);
            if (ferr[i] === 1'b1) ferr_cnt++;
        end
    end

    // Reference model: transmit buffer, its free flag and the last received word per instance.
    logic [W-1:0] m_buf [2];
    bit           m_ready [2];
    logic [W-1:0] m_last_rx [2];
    logic [W-1:0] exp_miso_q[$], got_miso_q[$], exp_rx_q[$];

    logic [W-1:0] xw [4];
    logic [W-1:0] xl [4];
    bit           xl_en [4];

    task automatic load(input int idx, input logic [W-1:0] v);
        @(negedge clk);
        txd[idx] = v;
        txl[idx] = 1'b1;
        @(negedge clk);
        txl[idx] = 1'b0;
        if (m_ready[idx]) begin
            m_buf[idx]   = v;
            m_ready[idx] = 1'b0;
        end
        chk("tx_ready after load", txr[idx], m_ready[idx]);
    endtask

    task automatic xfer(input int idx, input int nw, input int part, input bit rst_mid);
        bit pol, ph, msb;
        logic [W-1:0] cur, cap;
        int nb, b;
        pol = (idx == 1);
        ph  = (idx == 1);
        msb = (idx == 0);
        @(negedge clk);
        cs_v[idx] = 1'b0;
        cur = m_buf[idx];
        m_ready[idx] = 1'b1;
        repeat (H) @(negedge clk);
        for (int w = 0; w < nw + ((part > 0) ? 1 : 0); w++) begin
            nb  = (w < nw) ? W : part;
            cap = '0;
            for (int i = 0; i < nb; i++) begin
                b = msb ? (W - 1 - i) : i;
                if (i == 1 && xl_en[w]) load(idx, xl[w]);
                if (!ph) begin
                    mosi_v[idx] = xw[w][b];
                    repeat (H) @(negedge clk);
                    cap[b] = miso_w[idx];
                    sclk_v[idx] = ~pol;
                    repeat (H) @(negedge clk);
                    sclk_v[idx] = pol;
                end else begin
                    sclk_v[idx] = ~pol;
                    mosi_v[idx] = xw[w][b];
                    repeat (H) @(negedge clk);
                    cap[b] = miso_w[idx];
                    sclk_v[idx] = pol;
                    repeat (H) @(negedge clk);
                end
            end
            if (w < nw) begin
                got_miso_q.push_back(cap);
                exp_miso_q.push_back(cur);
                exp_rx_q.push_back(xw[w]);
                m_last_rx[idx] = xw[w];
                cur = m_buf[idx];
                m_ready[idx] = 1'b1;
            end
        end
        if (rst_mid) begin
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            chk("mid-frame reset miso", miso_w[idx], 0);
            chk("mid-frame reset rx_data", rxd[idx], 0);
            chk("mid-frame reset rx_valid", rxv[idx], 0);
            chk("mid-frame reset frame_err", ferr[idx], 0);
            chk("mid-frame reset tx_ready", txr[idx], 1);
            m_buf[idx]     = '0;
            m_ready[idx]   = 1'b1;
            m_last_rx[idx] = '0;
        end
        repeat (H) @(negedge clk);
        cs_v[idx] = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int idx, input int nw, input int part,
                             input bit rst_mid, input int exp_ferr);
        int rx0, fe0;
        exp_rx_q.delete();
        exp_miso_q.delete();
        got_miso_q.delete();
        rx0 = got_rx_q.size();
        fe0 = ferr_cnt;
        xfer(idx, nw, part, rst_mid);
        chk({tag, " rx_valid count"}, got_rx_q.size() - rx0, exp_rx_q.size());
        for (int k = 0; k < exp_rx_q.size(); k++)
            if (rx0 + k < got_rx_q.size())
                chk({tag, " rx word"}, got_rx_q[rx0 + k], exp_rx_q[k]);
        for (int k = 0; k < exp_miso_q.size(); k++)
            chk({tag, " miso word"}, got_miso_q[k], exp_miso_q[k]);
        chk({tag, " frame_err count"}, ferr_cnt - fe0, exp_ferr);
        chk({tag, " rx_data held"}, rxd[idx], m_last_rx[idx]);
        for (int k = 0; k < 4; k++) xl_en[k] = 1'b0;
    endtask

    typedef struct {
        int           idx;
        logic [W-1:0] tx;
        logic [W-1:0] mo;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_miso;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
        vt[1] = '{0, 8'h5A, 8'hFF, 8'hFF, 8'h5A};
        vt[2] = '{0, 8'h81, 8'h00, 8'h00, 8'h81};
        vt[3] = '{1, 8'h96, 8'h81, 8'h81, 8'h96};
        vt[4] = '{1, 8'h01, 8'hFE, 8'hFE, 8'h01};

        rst    = 1'b0;
        sclk_v = 2'b10;
        cs_v   = 2'b11;
        mosi_v = 2'b00;
        txl    = 2'b00;
        txd[0] = '0;
        txd[1] = '0;
        for (int i = 0; i < 2; i++) begin
            m_buf[i] = '0; m_ready[i] = 1'b1; m_last_rx[i] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            xw[k] = '0; xl[k] = '0; xl_en[k] = 1'b0;
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset miso", miso_w[i], 0);
            chk("reset rx_data", rxd[i], 0);
            chk("reset rx_valid", rxv[i], 0);
            chk("reset frame_err", ferr[i], 0);
            chk("reset tx_ready", txr[i], 1);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            load(vt[t].idx, vt[t].tx);
            xw[0] = vt[t].mo;
            run_frame("table", vt[t].idx, 1, 0, 1'b0, 0);
            if (got_miso_q.size() > 0) chk("table miso", got_miso_q[0], vt[t].exp_miso);
            chk("table rx_data", rxd[vt[t].idx], vt[t].exp_rx);
        end

        // Back-to-back words, new buffer loaded after the first reload.
        load(0, 8'h3C);
        xw[0] = 8'h12; xw[1] = 8'h34;
        xl[0] = 8'h55; xl_en[0] = 1'b1;
        run_frame("two words", 0, 2, 0, 1'b0, 0);
        if (got_miso_q.size() == 2) begin
            chk("two words miso0", got_miso_q[0], 8'h3C);
            chk("two words miso1", got_miso_q[1], 8'h55);
        end

        // Second load while not ready is dropped; the buffer is then retransmitted unchanged.
        load(0, 8'hAA);
        load(0, 8'hBB);
        xw[0] = 8'h66;
        run_frame("drop load", 0, 1, 0, 1'b0, 0);
        if (got_miso_q.size() == 1) chk("drop load miso", got_miso_q[0], 8'hAA);
        xw[0] = 8'h99;
        run_frame("retransmit", 0, 1, 0, 1'b0, 0);
        if (got_miso_q.size() == 1) chk("retransmit miso", got_miso_q[0], 8'hAA);

        // Abort after 3 bits, then a clean frame.
        xw[0] = 8'hE7;
        run_frame("abort", 0, 0, 3, 1'b0, 1);
        xw[0] = 8'hC3;
        run_frame("after abort", 0, 1, 0, 1'b0, 0);
        chk("after abort rx_data", rxd[0], 8'hC3);

        // Reset after 4 bits, then a clean frame from an empty buffer.
        xw[0] = 8'h5D;
        xl[0] = 8'h77; xl_en[0] = 1'b1;
        run_frame("reset mid", 0, 0, 4, 1'b1, 0);
        xw[0] = 8'h0F;
        run_frame("after reset", 0, 1, 0, 1'b0, 0);
        chk("after reset rx_data", rxd[0], 8'h0F);

        for (int r = 0; r < 10; r++) begin
            int idx, nw, part;
            idx  = r % 2;
            nw   = $urandom_range(1, 3);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
            if ($urandom_range(0, 1) == 1) load(idx, W'($urandom));
            for (int k = 0; k < 4; k++) begin
                xw[k]    = W'($urandom);
                xl[k]    = W'($urandom);
                xl_en[k] = ($urandom_range(0, 1) == 1);
            end
            run_frame("random", idx, nw, part, 1'b0, (part > 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_word.md
SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits (>=2).
REQ-002 Parameter: CPOL, default 0, sclk idle level.
REQ-003 Parameter: CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter: MSB_FIRST, default 1, 1 = MSB first on both mosi and miso, 0 = LSB first.
REQ-005 Port: clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port: rst  in  1  reset; one clock; reset is synchronous and active-low.
REQ-007 Port: sclk  in  1  SPI serial clock, asynchronous to clk.
REQ-008 Port: cs_n  in  1  chip select, active-low, asynchronous.
REQ-009 Port: mosi  in  1  serial data in, asynchronous.
REQ-010 Port: miso  out  1  serial data out.
REQ-011 Port: tx_data  in  WIDTH  word to transmit.
REQ-012 Port: tx_load  in  1  write strobe for tx_data.
REQ-013 Port: tx_ready  out  1  transmit buffer free.
REQ-014 Port: rx_data  out  WIDTH  last complete received word, held until the next one.
REQ-015 Port: rx_valid  out  1  one-cycle pulse, new rx_data.
REQ-016 Port: frame_err  out  1  one-cycle pulse, frame aborted mid-word.

Function
REQ-017 sclk, cs_n and mosi SHALL each pass a 2-flop synchroniser; sclk edges SHALL be detected with a third register (latency 3 clk from pin to edge event).
REQ-018 clk SHALL be >= 4x the sclk frequency; slower clk ratios are unsupported.
REQ-019 Leading edge = synchronised sclk leaving CPOL; trailing edge = returning to CPOL.
REQ-020 Sample edge = leading if CPHA=0, else trailing; shift edge = the other edge.
REQ-021 FSM states: IDLE (cs_n high) and ACTIVE (cs_n low).
REQ-022 IDLE->ACTIVE on synchronised cs_n falling:
- bit counter <= 0;
- tx shift register <= tx buffer;
- tx_ready <= 1.
REQ-023 ACTIVE, on a sample edge: shift the synchronised mosi into the rx shift register; counter increments.
REQ-024 On the sample edge with counter = WIDTH-1:
- rx_data <= assembled word, rx_valid pulses in the next clk;
- counter wraps to 0;
- tx shift register reloads from the tx buffer, so back-to-back words need no cs_n toggle.
REQ-025 ACTIVE, on a shift edge: tx shift register advances one bit; with CPHA=1 the first shift edge of each word SHALL NOT advance, because the first bit is presented on it.
REQ-026 miso SHALL equal the current tx bit (MSB or LSB per MSB_FIRST) while ACTIVE, and 0 while IDLE; no tristate.
REQ-027 ACTIVE->IDLE on synchronised cs_n rising:
- counter != 0: frame_err pulses 1 clk, partial word discarded, rx_data unchanged;
- counter = 0: no pulse.
REQ-028 Sample edge and cs_n rise detected in the same clk: cs_n rise wins, the edge is ignored.
REQ-029 tx_load with tx_ready=1: tx buffer <= tx_data, tx_ready <= 0 in the next clk.
REQ-030 tx_load with tx_ready=0 SHALL be ignored; buffer unchanged.
REQ-031 tx_ready SHALL return to 1 in the clk after the buffer is copied into the tx shift register.
REQ-032 No new tx_load before a reload: the buffer content is retransmitted unchanged.
REQ-033 tx_load in the same clk as a reload: the reload takes the old buffer, the new data is stored, tx_ready stays 0.

Reset
REQ-034 rst=0 at a clk edge SHALL force:
- FSM to IDLE, counter 0, shift registers 0, tx buffer 0, synchronisers to idle values (sclk=CPOL, cs_n=1, mosi=0);
- outputs: miso=0, rx_data=0, rx_valid=0, frame_err=0, tx_ready=1.
REQ-035 A reset mid-frame SHALL produce no rx_valid or frame_err for that frame.
REQ-036 After reset is released, the block SHALL wait for a fresh cs_n falling edge before receiving.

Verification
REQ-037 WIDTH=8, mode 0, tx_load 0x3C, cs_n low, 8 sclk with mosi 0xA5 -> rx_data=0xA5, exactly one rx_valid pulse; miso bits 0,0,1,1,1,1,0,0.
REQ-038 Two words 0x12, 0x34 in one cs_n low; 0x55 loaded after the first reload -> two rx_valid pulses, rx_data 0x12 then 0x34; miso 0x3C then 0x55.
REQ-039 cs_n raised after 3 bits -> frame_err one pulse, no rx_valid, rx_data unchanged; next full frame 0xC3 received correctly.
REQ-040 CPOL=1, CPHA=1, MSB_FIRST=0, mosi word 0x81 -> rx_data=0x81; miso carries the tx buffer LSB first.
REQ-041 tx_load 0xAA then tx_load 0xBB while tx_ready=0 -> 0xAA transmitted, 0xBB dropped.
REQ-042 rst=0 after 4 bits -> all outputs at reset values next clk; no rx_valid or frame_err for that frame; next frame 0x0F received correctly.
